// File: rtl/dmi_req_buffer.sv
// dmi_req_buffer: FIFO-buffered DMI bridge with one outstanding transaction and a response watchdog; s_req/s_resp face the transport, m_req/m_resp the debug module, busy/timeout_count report status.
module dmi_req_buffer #(
  parameter int REQ_DEPTH  = 4,
  parameter int RESP_DEPTH = 4,
  parameter int ADDR_W     = 7,
  parameter int TIMEOUT    = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_req_valid,
  output logic              s_req_ready,
  input  logic [ADDR_W-1:0] s_req_addr,
  input  logic [31:0]       s_req_data,
  input  logic [1:0]        s_req_op,
  output logic              s_resp_valid,
  input  logic              s_resp_ready,
  output logic [31:0]       s_resp_data,
  output logic [1:0]        s_resp_resp,
  output logic              m_req_valid,
  input  logic              m_req_ready,
  output logic [ADDR_W-1:0] m_req_addr,
  output logic [31:0]       m_req_data,
  output logic [1:0]        m_req_op,
  input  logic              m_resp_valid,
  output logic              m_resp_ready,
  input  logic [31:0]       m_resp_data,
  input  logic [1:0]        m_resp_resp,
  output logic              busy,
  output logic [7:0]        timeout_count
);
  localparam int QA = $clog2(REQ_DEPTH);
  localparam int PA = $clog2(RESP_DEPTH);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int QW = ADDR_W + 34;
  localparam logic [QA:0] Q_FULL = (QA+1)'(REQ_DEPTH);
  localparam logic [PA:0] P_FULL = (PA+1)'(RESP_DEPTH);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, FLUSH} state_t;
  state_t state, state_d;
  logic [QW-1:0] req_mem [REQ_DEPTH];
  logic [33:0] resp_mem [RESP_DEPTH];
  logic [QA-1:0] req_wr, req_rd;
  logic [PA-1:0] resp_wr, resp_rd;
  logic [QA:0] req_cnt;
  logic [PA:0] resp_cnt;
  logic [QW-1:0] req_q;
  logic [WW-1:0] wd;
  logic req_push, req_pop, resp_push, resp_pop, resp_full, m_resp_hs, wd_hit;
  logic [33:0] resp_in, resp_head;
  assign s_req_ready = reset && req_cnt != Q_FULL;
  assign req_push = s_req_valid && s_req_ready;
  assign resp_full = resp_cnt == P_FULL;
  assign req_pop = state == IDLE && req_cnt != '0 && !resp_full;
  assign m_req_valid = state == ISSUE;
  assign {m_req_addr, m_req_data, m_req_op} = req_q;
  assign m_resp_ready = (state == WAIT && !resp_full) || state == FLUSH;
  assign m_resp_hs = m_resp_valid && m_resp_ready;
  assign wd_hit = wd == WD_MAX;
  assign resp_push = state == WAIT && (m_resp_hs || wd_hit);
  assign resp_in = m_resp_hs ? {m_resp_data, m_resp_resp} : {32'h0, 2'd2};
  assign s_resp_valid = resp_cnt != '0;
  assign resp_pop = s_resp_valid && s_resp_ready;
  assign resp_head = s_resp_valid ? resp_mem[resp_rd] : '0;
  assign {s_resp_data, s_resp_resp} = resp_head;
  assign busy = state != IDLE || req_cnt != '0 || s_resp_valid;
  always_comb
    state_d = state == IDLE  ? (req_pop ? ISSUE : IDLE)
            : state == ISSUE ? (m_req_ready ? WAIT : ISSUE)
            : state == WAIT  ? (m_resp_hs ? IDLE : wd_hit ? FLUSH : WAIT)
            : (m_resp_hs || wd_hit) ? IDLE : FLUSH;
  always_ff @(posedge clk) begin
    if (req_push) req_mem[req_wr] <= {s_req_addr, s_req_data, s_req_op};
    if (resp_push) resp_mem[resp_wr] <= resp_in;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      req_wr        <= '0;
      req_rd        <= '0;
      req_cnt       <= '0;
      resp_wr       <= '0;
      resp_rd       <= '0;
      resp_cnt      <= '0;
      req_q         <= '0;
      wd            <= '0;
      timeout_count <= '0;
    end else begin
      state <= state_d;
      if (req_push) req_wr <= req_wr + 1'b1;
      if (req_pop) begin
        req_rd <= req_rd + 1'b1;
        req_q  <= req_mem[req_rd];
      end
      req_cnt <= req_cnt + (QA+1)'(req_push) - (QA+1)'(req_pop);
      if (resp_push) resp_wr <= resp_wr + 1'b1;
      if (resp_pop) resp_rd <= resp_rd + 1'b1;
      resp_cnt <= resp_cnt + (PA+1)'(resp_push) - (PA+1)'(resp_pop);
      wd <= (state_d != state || state == IDLE || state == ISSUE) ? '0 : wd + 1'b1;
      if (resp_push && !m_resp_hs && timeout_count != 8'hff) timeout_count <= timeout_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_dmi_req_buffer.sv
// tb_dmi_req_buffer: directed scenarios plus randomized traffic against a queue-based transaction model.
module tb_dmi_req_buffer;
  localparam int AW = 7;
  logic clk = 1'b0;
  logic reset;
  logic s_req_valid, s_req_ready;
  logic [AW-1:0] s_req_addr;
  logic [31:0] s_req_data;
  logic [1:0] s_req_op;
  logic s_resp_valid, s_resp_ready;
  logic [31:0] s_resp_data;
  logic [1:0] s_resp_resp;
  logic m_req_valid, m_req_ready;
  logic [AW-1:0] m_req_addr;
  logic [31:0] m_req_data;
  logic [1:0] m_req_op;
  logic m_resp_valid, m_resp_ready;
  logic [31:0] m_resp_data;
  logic [1:0] m_resp_resp;
  logic busy;
  logic [7:0] timeout_count;
  int checks = 0, errors = 0, n_acc = 0, n_del = 0;
  logic [40:0] exp_req[$];
  logic [33:0] exp_resp[$];

  dmi_req_buffer #(.REQ_DEPTH(4), .RESP_DEPTH(4), .ADDR_W(AW), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_addr(s_req_addr),
    .s_req_data(s_req_data), .s_req_op(s_req_op),
    .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready),
    .s_resp_data(s_resp_data), .s_resp_resp(s_resp_resp),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
    .m_req_data(m_req_data), .m_req_op(m_req_op),
    .m_resp_valid(m_resp_valid), .m_resp_ready(m_resp_ready),
    .m_resp_data(m_resp_data), .m_resp_resp(m_resp_resp),
    .busy(busy), .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  task automatic clear_inputs;
    s_req_valid = 0; s_req_addr = '0; s_req_data = '0; s_req_op = '0;
    s_resp_ready = 0; m_req_ready = 0;
    m_resp_valid = 0; m_resp_data = '0; m_resp_resp = '0;
  endtask

  task automatic run_traffic(input int n_new, input int mode);
    int sent = 0, cyc = 0, dly = 0, r;
    bit pend = 0, acc_last = 0;
    logic [31:0] rd = '0;
    logic [1:0] rr = '0;
    logic [40:0] got, exp;
    logic [33:0] er;
    while ((mode == 2 ? exp_resp.size() < n_new : (sent < n_new || n_acc != n_del)) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      checks++;
      if (busy !== (n_acc != n_del)) begin
        errors++;
        $display("FAIL busy: got %b expected %b", busy, n_acc != n_del);
      end
      checks++;
      if (m_req_valid && pend) begin
        errors++;
        $display("FAIL one_outstanding: got m_req_valid=1 expected 0 while a response is owed");
      end
      if (pend && dly > 0) begin
        dly--;
        m_resp_valid = 0;
      end else if (pend) begin
        m_resp_valid = 1; m_resp_data = rd; m_resp_resp = rr;
        if (m_resp_ready) begin
          pend = 0;
          exp_resp.push_back({rd, rr});
        end
      end else m_resp_valid = 0;
      m_req_ready = mode == 1 ? 1'($urandom_range(0, 1)) : 1'b1;
      if (m_req_valid && m_req_ready) begin
        got = {m_req_addr, m_req_data, m_req_op};
        checks++;
        if (exp_req.size() == 0) begin
          errors++;
          $display("FAIL m_req_order: got %h expected no request", got);
        end else begin
          exp = exp_req.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL m_req_order: got %h expected %h", got, exp);
          end
        end
        pend = 1;
        dly = mode == 1 ? int'($urandom_range(0, 4)) : 0;
        rd = $urandom;
        r = int'($urandom_range(0, 2));
        rr = r == 0 ? 2'd0 : r == 1 ? 2'd2 : 2'd3;
      end
      if (acc_last) s_req_valid = 0;
      if (!s_req_valid && sent < n_new && (mode != 1 || $urandom_range(0, 1) == 1)) begin
        s_req_valid = 1; s_req_addr = AW'($urandom); s_req_data = $urandom; s_req_op = 2'($urandom);
      end
      acc_last = s_req_valid && s_req_ready;
      if (acc_last) begin
        exp_req.push_back({s_req_addr, s_req_data, s_req_op});
        n_acc++;
        sent++;
      end
      s_resp_ready = mode == 2 ? 1'b0 : mode == 1 ? 1'($urandom_range(0, 1)) : 1'b1;
      if (s_resp_valid && s_resp_ready) begin
        checks++;
        if (exp_resp.size() == 0) begin
          errors++;
          $display("FAIL s_resp_order: got %h expected no response", {s_resp_data, s_resp_resp});
        end else begin
          er = exp_resp.pop_front();
          if ({s_resp_data, s_resp_resp} !== er) begin
            errors++;
            $display("FAIL s_resp_order: got %h expected %h", {s_resp_data, s_resp_resp}, er);
          end
        end
        n_del++;
      end
    end
    checks++;
    if (cyc >= 5000) begin
      errors++;
      $display("FAIL traffic_budget: got %0d cycles expected < 5000", cyc);
    end
    @(negedge clk);
    s_req_valid = 0; m_resp_valid = 0; s_resp_ready = 0; m_req_ready = 0;
  endtask

  task automatic test_reset;
    reset = 0;
    clear_inputs();
    #2;
    checks++;
    if ({s_req_ready, s_resp_valid, m_req_valid, m_resp_ready, busy} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 00000", {s_req_ready, s_resp_valid, m_req_valid, m_resp_ready, busy});
    end
    checks++;
    if ({s_resp_data, s_resp_resp, m_req_addr, m_req_data, m_req_op, timeout_count} !== 83'h0) begin
      errors++;
      $display("FAIL reset_data: got %h expected 0", {s_resp_data, s_resp_resp, m_req_addr, m_req_data, m_req_op, timeout_count});
    end
    repeat (2) @(negedge clk);
    reset = 1;
    @(negedge clk);
    checks++;
    if ({s_req_ready, busy} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release: got %b expected 10", {s_req_ready, busy});
    end
  endtask

  task automatic test_write;
    @(negedge clk);
    s_req_valid = 1; s_req_addr = 7'h10; s_req_data = 32'hDEADBEEF; s_req_op = 2'd2;
    m_req_ready = 1; s_resp_ready = 0;
    checks++;
    if (s_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_accept: got %b expected 1", s_req_ready);
    end
    @(negedge clk);
    s_req_valid = 0;
    checks++;
    if (m_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL wr_lat_n1: got m_req_valid=%b expected 0", m_req_valid);
    end
    @(negedge clk);
    checks++;
    if ({m_req_valid, m_req_addr, m_req_data, m_req_op} !== {1'b1, 7'h10, 32'hDEADBEEF, 2'd2}) begin
      errors++;
      $display("FAIL wr_m_req: got %h expected %h", {m_req_valid, m_req_addr, m_req_data, m_req_op}, {1'b1, 7'h10, 32'hDEADBEEF, 2'd2});
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({m_req_valid, s_resp_valid} !== 2'b00) begin
        errors++;
        $display("FAIL wr_wait: got %b expected 00", {m_req_valid, s_resp_valid});
      end
    end
    @(negedge clk);
    m_resp_valid = 1; m_resp_data = 32'h0; m_resp_resp = 2'd0;
    checks++;
    if (m_resp_ready !== 1'b1) begin
      errors++;
      $display("FAIL wr_m_resp_ready: got %b expected 1", m_resp_ready);
    end
    @(negedge clk);
    m_resp_valid = 0;
    checks++;
    if ({s_resp_valid, s_resp_data, s_resp_resp} !== {1'b1, 34'h0}) begin
      errors++;
      $display("FAIL wr_resp: got %h expected %h", {s_resp_valid, s_resp_data, s_resp_resp}, {1'b1, 34'h0});
    end
    s_resp_ready = 1;
    @(negedge clk);
    s_resp_ready = 0;
    checks++;
    if ({s_resp_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL wr_drain: got %b expected 00", {s_resp_valid, busy});
    end
  endtask

  task automatic test_back_to_back;
    m_req_ready = 0; s_resp_ready = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (s_req_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready_%0d: got %b expected 1", k, s_req_ready);
      end
      s_req_valid = 1; s_req_addr = AW'($urandom); s_req_data = $urandom; s_req_op = 2'(k);
      exp_req.push_back({s_req_addr, s_req_data, s_req_op});
      n_acc++;
    end
    @(negedge clk);
    s_req_valid = 0;
    checks++;
    if (s_req_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_full: got %b expected 0", s_req_ready);
    end
    checks++;
    if ({m_req_valid, m_req_addr, m_req_data, m_req_op} !== {1'b1, exp_req[0]}) begin
      errors++;
      $display("FAIL b2b_issue: got %h expected %h", {m_req_valid, m_req_addr, m_req_data, m_req_op}, {1'b1, exp_req[0]});
    end
    run_traffic(0, 0);
  endtask

  task automatic test_resp_full;
    run_traffic(4, 2);
    @(negedge clk);
    m_resp_valid = 0;
    s_req_valid = 1; s_req_addr = 7'h55; s_req_data = $urandom; s_req_op = 2'd1;
    checks++;
    if (s_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rf_accept: got %b expected 1", s_req_ready);
    end
    exp_req.push_back({s_req_addr, s_req_data, s_req_op});
    n_acc++;
    @(negedge clk);
    s_req_valid = 0;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if ({m_req_valid, s_resp_valid} !== 2'b01) begin
        errors++;
        $display("FAIL rf_hold: got m_req_valid,s_resp_valid=%b expected 01", {m_req_valid, s_resp_valid});
      end
    end
    run_traffic(0, 0);
  endtask

  task automatic test_timeout;
    @(negedge clk);
    s_req_valid = 1; s_req_addr = 7'h22; s_req_data = 32'h0; s_req_op = 2'd1;
    m_req_ready = 1; s_resp_ready = 0;
    @(negedge clk);
    s_req_valid = 0;
    @(negedge clk);
    checks++;
    if (m_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL to_issue: got %b expected 1", m_req_valid);
    end
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      checks++;
      if ({s_resp_valid, m_resp_ready} !== 2'b01) begin
        errors++;
        $display("FAIL to_early_%0d: got s_resp_valid,m_resp_ready=%b expected 01", k, {s_resp_valid, m_resp_ready});
      end
    end
    @(negedge clk);
    checks++;
    if ({s_resp_valid, s_resp_data, s_resp_resp, timeout_count, m_resp_ready} !== {1'b1, 32'h0, 2'd2, 8'd1, 1'b1}) begin
      errors++;
      $display("FAIL to_resp: got %h expected %h", {s_resp_valid, s_resp_data, s_resp_resp, timeout_count, m_resp_ready}, {1'b1, 32'h0, 2'd2, 8'd1, 1'b1});
    end
    m_resp_valid = 1; m_resp_data = 32'h12345678; m_resp_resp = 2'd0;
    @(negedge clk);
    m_resp_valid = 0; s_resp_ready = 1;
    @(negedge clk);
    s_resp_ready = 0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({s_resp_valid, busy, timeout_count} !== {2'b00, 8'd1}) begin
        errors++;
        $display("FAIL to_late_drop: got %h expected %h", {s_resp_valid, busy, timeout_count}, {2'b00, 8'd1});
      end
    end
  endtask

  task automatic test_busy_resp;
    @(negedge clk);
    s_req_valid = 1; s_req_addr = 7'h05; s_req_data = 32'h0; s_req_op = 2'd1;
    m_req_ready = 1; s_resp_ready = 0;
    @(negedge clk);
    s_req_valid = 0;
    @(negedge clk);
    @(negedge clk);
    m_resp_valid = 1; m_resp_data = 32'hCAFEF00D; m_resp_resp = 2'd3;
    @(negedge clk);
    m_resp_valid = 0;
    checks++;
    if ({s_resp_valid, s_resp_data, s_resp_resp} !== {1'b1, 32'hCAFEF00D, 2'd3}) begin
      errors++;
      $display("FAIL busy_resp: got %h expected %h", {s_resp_valid, s_resp_data, s_resp_resp}, {1'b1, 32'hCAFEF00D, 2'd3});
    end
    s_resp_ready = 1;
    @(negedge clk);
    s_resp_ready = 0;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    s_req_valid = 1; s_req_addr = 7'h33; s_req_data = $urandom; s_req_op = 2'd1;
    m_req_ready = 1; s_resp_ready = 0;
    @(negedge clk);
    s_req_valid = 0;
    @(negedge clk);
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, m_resp_ready} !== 2'b11) begin
      errors++;
      $display("FAIL rm_wait: got %b expected 11", {busy, m_resp_ready});
    end
    #2 reset = 0;
    #1;
    checks++;
    if ({s_req_ready, s_resp_valid, m_req_valid, m_resp_ready, busy} !== 5'b0) begin
      errors++;
      $display("FAIL rm_ctrl: got %b expected 00000", {s_req_ready, s_resp_valid, m_req_valid, m_resp_ready, busy});
    end
    checks++;
    if ({s_resp_data, s_resp_resp, m_req_addr, m_req_data, m_req_op, timeout_count} !== 83'h0) begin
      errors++;
      $display("FAIL rm_data: got %h expected 0", {s_resp_data, s_resp_resp, m_req_addr, m_req_data, m_req_op, timeout_count});
    end
    @(negedge clk);
    reset = 1;
    m_resp_valid = 1; m_resp_data = 32'hBADBAD00; m_resp_resp = 2'd0;
    repeat (4) begin
      @(negedge clk);
      checks++;
      if ({s_req_ready, s_resp_valid, busy, m_resp_ready} !== 4'b1000) begin
        errors++;
        $display("FAIL rm_after: got %b expected 1000", {s_req_ready, s_resp_valid, busy, m_resp_ready});
      end
    end
    m_resp_valid = 0; m_req_ready = 0;
  endtask

  task automatic test_random;
    run_traffic(80, 1);
    checks++;
    if ({exp_req.size() == 0, exp_resp.size() == 0, busy} !== 3'b110) begin
      errors++;
      $display("FAIL rand_end: got %0d reqs %0d resps busy=%b expected 0 0 0", exp_req.size(), exp_resp.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_back_to_back();
    test_resp_full();
    test_timeout();
    test_busy_resp();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
